// File: rtl/multicycle_control_pkg.sv
// legv8_ctrl_pkg: shared types and constants for the LEGv8 multi-cycle control slice.
//   state_e  - sequencer states (FETCH, DECODE, EXEC, MEM, WB, HALT)
//   iclass_e - decoded instruction class
//   ALU_*    - aluop encodings driven to the ALU
//   SIGN_*   - signop encodings driven to the sign-extender
//   PAT_*    - opcode (IR[31:21]) wildcard patterns
//   classify - opcode -> instruction class, first match wins
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_ILLEGAL,
        CL_ANDREG,
        CL_ORRREG,
        CL_ADDREG,
        CL_SUBREG,
        CL_ADDIMM,
        CL_SUBIMM,
        CL_LDUR,
        CL_STUR,
        CL_CBZ,
        CL_B
    } iclass_e;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [1:0] SIGN_I  = 2'b00;
    localparam logic [1:0] SIGN_D  = 2'b01;
    localparam logic [1:0] SIGN_B  = 2'b10;
    localparam logic [1:0] SIGN_CB = 2'b11;

    localparam logic [10:0] PAT_LDUR   = 11'b??111000010;
    localparam logic [10:0] PAT_STUR   = 11'b??111000000;
    localparam logic [10:0] PAT_ANDREG = 11'b?0001010???;
    localparam logic [10:0] PAT_ORRREG = 11'b?0101010???;
    localparam logic [10:0] PAT_ADDREG = 11'b?0?01011???;
    localparam logic [10:0] PAT_SUBREG = 11'b?1?01011???;
    localparam logic [10:0] PAT_ADDIMM = 11'b?0?10001???;
    localparam logic [10:0] PAT_SUBIMM = 11'b?1?10001???;
    localparam logic [10:0] PAT_CBZ    = 11'b?011010????;
    localparam logic [10:0] PAT_B      = 11'b?00101?????;

    // Item order sets priority: memory ops, then R-type, I-type, CBZ, B.
    function automatic iclass_e classify(input logic [10:0] op);
        iclass_e c;
        c = CL_ILLEGAL;
        casez (op)
            PAT_LDUR:   c = CL_LDUR;
            PAT_STUR:   c = CL_STUR;
            PAT_ANDREG: c = CL_ANDREG;
            PAT_ORRREG: c = CL_ORRREG;
            PAT_ADDREG: c = CL_ADDREG;
            PAT_SUBREG: c = CL_SUBREG;
            PAT_ADDIMM: c = CL_ADDIMM;
            PAT_SUBIMM: c = CL_SUBIMM;
            PAT_CBZ:    c = CL_CBZ;
            PAT_B:      c = CL_B;
            default:    c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// mc_decode: combinational opcode decoder for the multi-cycle LEGv8 control.
// Ports:
//   opcode  in  11  IR[31:21] (live in DECODE, latched copy afterwards)
//   iclass  out     instruction class
//   aluop   out  4  ALU operation for the class
//   alusrc  out  1  ALU B from sign-extended immediate
//   reg2loc out  1  Rt as second read register
//   signop  out  2  sign-extender format
module mc_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_e     iclass,
    output logic [3:0]  aluop,
    output logic        alusrc,
    output logic        reg2loc,
    output logic [1:0]  signop
);

    always_comb begin
        iclass  = classify(opcode);
        aluop   = ALU_AND;
        alusrc  = 1'b0;
        reg2loc = 1'b0;
        signop  = SIGN_I;
        unique case (iclass)
            CL_ANDREG: aluop = ALU_AND;
            CL_ORRREG: aluop = ALU_ORR;
            CL_ADDREG: aluop = ALU_ADD;
            CL_SUBREG: aluop = ALU_SUB;
            CL_ADDIMM: begin
                aluop  = ALU_ADD;
                alusrc = 1'b1;
            end
            CL_SUBIMM: begin
                aluop  = ALU_SUB;
                alusrc = 1'b1;
            end
            CL_LDUR: begin
                aluop  = ALU_ADD;
                alusrc = 1'b1;
                signop = SIGN_D;
            end
            CL_STUR: begin
                aluop   = ALU_ADD;
                alusrc  = 1'b1;
                reg2loc = 1'b1;
                signop  = SIGN_D;
            end
            CL_CBZ: begin
                aluop   = ALU_PASSB;
                reg2loc = 1'b1;
                signop  = SIGN_CB;
            end
            CL_B:       signop = SIGN_B;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle sequencer for the LEGv8 datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB per instruction, handshaking with a
// variable-latency unified memory through mem_req/mem_ready.
// Optional feature macro: MC_PERF_CNT_EN adds parameter CNT_W and the
// cycle_cnt/instr_cnt performance counter outputs.
// Ports:
//   CLK, resetl         clock (rising edge), async active-low reset
//   opcode[10:0]        IR[31:21], sampled in DECODE
//   zero                ALU zero flag, used by CBZ in EXEC
//   mem_ready           memory completion (same-cycle allowed)
//   mem_req/read/write  memory access request and direction
//   ir_write, pc_write, pc_src            IR/PC update strobes
//   reg2loc, alusrc, mem2reg, regwrite    datapath selects/strobes
//   aluop[3:0], signop[1:0]               ALU op, sign-extend format
//   illegal             sticky unsupported-opcode flag
//   cycle_cnt, instr_cnt (MC_PERF_CNT_EN only) wrapping counters
module multicycle_control
    import legv8_ctrl_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic        CLK,
    input  logic        resetl,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic [3:0]  aluop,
    output logic [1:0]  signop,
    output logic        illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_e      state_q, state_d;
    logic [10:0] opcode_q, opcode_d;
    logic        illegal_q, illegal_d;

    iclass_e     cls;
    logic [3:0]  dec_aluop;
    logic        dec_alusrc;
    logic        dec_reg2loc;
    logic [1:0]  dec_signop;

    logic        fsm_mem_req, fsm_mem_read, fsm_mem_write;
    logic        fsm_ir_write, fsm_pc_write, fsm_pc_src;
    logic        fsm_mem2reg, fsm_regwrite;
    logic        ctrl_phase;

    // The opcode is taken live in DECODE and frozen afterwards, so the
    // decoder always sees the instruction currently being executed.
    always_comb begin
        opcode_d = (state_q == ST_DECODE) ? opcode : opcode_q;
    end

    mc_decode u_decode (
        .opcode  (opcode_d),
        .iclass  (cls),
        .aluop   (dec_aluop),
        .alusrc  (dec_alusrc),
        .reg2loc (dec_reg2loc),
        .signop  (dec_signop)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        fsm_mem_req   = 1'b0;
        fsm_mem_read  = 1'b0;
        fsm_mem_write = 1'b0;
        fsm_ir_write  = 1'b0;
        fsm_pc_write  = 1'b0;
        fsm_pc_src    = 1'b0;
        fsm_mem2reg   = 1'b0;
        fsm_regwrite  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                fsm_mem_req  = 1'b1;
                fsm_mem_read = 1'b1;
                if (mem_ready) begin
                    fsm_ir_write = 1'b1;
                    fsm_pc_write = 1'b1;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cls == CL_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                unique case (cls)
                    CL_LDUR, CL_STUR: state_d = ST_MEM;
                    CL_CBZ: begin
                        fsm_pc_write = zero;
                        fsm_pc_src   = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    CL_B: begin
                        fsm_pc_write = 1'b1;
                        fsm_pc_src   = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                fsm_mem_req   = 1'b1;
                fsm_mem_read  = (cls == CL_LDUR);
                fsm_mem_write = (cls == CL_STUR);
                if (mem_ready) begin
                    state_d = (cls == CL_LDUR) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                fsm_regwrite = 1'b1;
                fsm_mem2reg  = (cls == CL_LDUR);
                state_d      = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset puts the state in FETCH asynchronously; gating with resetl keeps
    // every strobe (notably mem_req) low for as long as reset is held.
    always_comb begin
        ctrl_phase = resetl && (state_q inside {ST_EXEC, ST_MEM, ST_WB});
        mem_req    = fsm_mem_req   & resetl;
        mem_read   = fsm_mem_read  & resetl;
        mem_write  = fsm_mem_write & resetl;
        ir_write   = fsm_ir_write  & resetl;
        pc_write   = fsm_pc_write  & resetl;
        pc_src     = fsm_pc_src    & resetl;
        mem2reg    = fsm_mem2reg   & resetl;
        regwrite   = fsm_regwrite  & resetl;
        aluop      = ctrl_phase ? dec_aluop  : '0;
        alusrc     = ctrl_phase ? dec_alusrc : 1'b0;
        reg2loc    = ctrl_phase ? dec_reg2loc : 1'b0;
        signop     = ctrl_phase ? dec_signop : '0;
        illegal    = illegal_q;
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             retire;

    // An instruction retires on the cycle it leaves its last state.
    always_comb begin
        retire = (state_q == ST_WB)
              || ((state_q == ST_MEM)  && (cls == CL_STUR) && mem_ready)
              || ((state_q == ST_EXEC) && ((cls == CL_CBZ) || (cls == CL_B)));
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        instr_cnt_d = retire ? (instr_cnt_q + CNT_W'(1)) : instr_cnt_q;
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    always_comb begin
        cycle_cnt = cycle_cnt_q;
        instr_cnt = instr_cnt_q;
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic        reg2loc, alusrc, mem2reg, regwrite, illegal;
  logic [3:0]  aluop;
  logic [1:0]  signop;
`ifdef MC_PERF_CNT_EN
  logic [3:0]  cycle_cnt, instr_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 CLK = ~CLK;

`ifdef MC_PERF_CNT_EN
  multicycle_control #(.CNT_W(4)) dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg2loc   (reg2loc),
    .alusrc    (alusrc),
    .mem2reg   (mem2reg),
    .regwrite  (regwrite),
    .aluop     (aluop),
    .signop    (signop),
    .illegal   (illegal),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );
`else
  multicycle_control dut (
    .CLK       (CLK),
    .resetl    (resetl),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg2loc   (reg2loc),
    .alusrc    (alusrc),
    .mem2reg   (mem2reg),
    .regwrite  (regwrite),
    .aluop     (aluop),
    .signop    (signop),
    .illegal   (illegal)
  );
`endif

  // {req rd wr}_{irw pcw pcs}_{r2l asrc m2r rw}_{aluop}_{signop}_{illegal}
  logic [16:0] obs;
  assign obs = {mem_req, mem_read, mem_write, ir_write, pc_write, pc_src,
                reg2loc, alusrc, mem2reg, regwrite, aluop, signop, illegal};

  localparam logic [10:0] OP_ADDREG = 11'b10001011000;
  localparam logic [10:0] OP_SUBREG = 11'b11001011000;
  localparam logic [10:0] OP_ANDREG = 11'b10001010000;
  localparam logic [10:0] OP_ORRREG = 11'b10101010000;
  localparam logic [10:0] OP_ADDIMM = 11'b10010001000;
  localparam logic [10:0] OP_SUBIMM = 11'b11010001000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] OP_BAD    = 11'b11111111111;

  localparam logic [16:0] E_F_RDY  = 17'b110_110_0000_0000_00_0;
  localparam logic [16:0] E_F_WAIT = 17'b110_000_0000_0000_00_0;
  localparam logic [16:0] E_DEC    = 17'b000_000_0000_0000_00_0;
  localparam logic [16:0] E_HALT   = 17'b000_000_0000_0000_00_1;

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [10:0] op, input logic z,
                     input logic rdy, input logic [16:0] e);
    vec_t v;
    v.name = n; v.op = op; v.z = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    resetl = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;

    // ADDREG: opcode changed after DECODE must be ignored
    add("add_f",  OP_ADDREG, 0, 1, E_F_RDY);
    add("add_d",  OP_ADDREG, 0, 1, E_DEC);
    add("add_e",  OP_BAD,    0, 1, 17'b000_000_0000_0010_00_0);
    add("add_w",  OP_BAD,    0, 1, 17'b000_000_0001_0010_00_0);
    // SUBREG with two fetch wait cycles
    add("sub_fw0", OP_SUBREG, 0, 0, E_F_WAIT);
    add("sub_fw1", OP_SUBREG, 0, 0, E_F_WAIT);
    add("sub_f",  OP_SUBREG, 0, 1, E_F_RDY);
    add("sub_d",  OP_SUBREG, 0, 1, E_DEC);
    add("sub_e",  OP_SUBREG, 0, 1, 17'b000_000_0000_0110_00_0);
    add("sub_w",  OP_SUBREG, 0, 1, 17'b000_000_0001_0110_00_0);
    add("and_f",  OP_ANDREG, 0, 1, E_F_RDY);
    add("and_d",  OP_ANDREG, 0, 1, E_DEC);
    add("and_e",  OP_ANDREG, 0, 1, 17'b000_000_0000_0000_00_0);
    add("and_w",  OP_ANDREG, 0, 1, 17'b000_000_0001_0000_00_0);
    add("orr_f",  OP_ORRREG, 0, 1, E_F_RDY);
    add("orr_d",  OP_ORRREG, 0, 1, E_DEC);
    add("orr_e",  OP_ORRREG, 0, 1, 17'b000_000_0000_0001_00_0);
    add("orr_w",  OP_ORRREG, 0, 1, 17'b000_000_0001_0001_00_0);
    add("addi_f", OP_ADDIMM, 0, 1, E_F_RDY);
    add("addi_d", OP_ADDIMM, 0, 1, E_DEC);
    add("addi_e", OP_ADDIMM, 0, 1, 17'b000_000_0100_0010_00_0);
    add("addi_w", OP_ADDIMM, 0, 1, 17'b000_000_0101_0010_00_0);
    add("subi_f", OP_SUBIMM, 0, 1, E_F_RDY);
    add("subi_d", OP_SUBIMM, 0, 1, E_DEC);
    add("subi_e", OP_SUBIMM, 0, 1, 17'b000_000_0100_0110_00_0);
    add("subi_w", OP_SUBIMM, 0, 1, 17'b000_000_0101_0110_00_0);
    // LDUR with three memory wait cycles: 8 cycles total
    add("ld_f",   OP_LDUR, 0, 1, E_F_RDY);
    add("ld_d",   OP_LDUR, 0, 1, E_DEC);
    add("ld_e",   OP_LDUR, 0, 1, 17'b000_000_0100_0010_01_0);
    add("ld_mw0", OP_LDUR, 0, 0, 17'b110_000_0100_0010_01_0);
    add("ld_mw1", OP_LDUR, 0, 0, 17'b110_000_0100_0010_01_0);
    add("ld_mw2", OP_LDUR, 0, 0, 17'b110_000_0100_0010_01_0);
    add("ld_m",   OP_LDUR, 0, 1, 17'b110_000_0100_0010_01_0);
    add("ld_w",   OP_LDUR, 0, 1, 17'b000_000_0111_0010_01_0);
    add("st_f",   OP_STUR, 0, 1, E_F_RDY);
    add("st_d",   OP_STUR, 0, 1, E_DEC);
    add("st_e",   OP_STUR, 0, 1, 17'b000_000_1100_0010_01_0);
    add("st_mw",  OP_STUR, 0, 0, 17'b101_000_1100_0010_01_0);
    add("st_m",   OP_STUR, 0, 1, 17'b101_000_1100_0010_01_0);
    add("cbz1_f", OP_CBZ, 1, 1, E_F_RDY);
    add("cbz1_d", OP_CBZ, 1, 1, E_DEC);
    add("cbz1_e", OP_CBZ, 1, 1, 17'b000_011_1000_0111_11_0);
    add("cbz0_f", OP_CBZ, 0, 1, E_F_RDY);
    add("cbz0_d", OP_CBZ, 0, 1, E_DEC);
    add("cbz0_e", OP_CBZ, 0, 1, 17'b000_001_1000_0111_11_0);
    add("b_f",    OP_B, 0, 1, E_F_RDY);
    add("b_d",    OP_B, 0, 1, E_DEC);
    add("b_e",    OP_B, 0, 1, 17'b000_011_0000_0000_10_0);
    add("bad_f",  OP_BAD, 0, 1, E_F_RDY);
    add("bad_d",  OP_BAD, 0, 1, E_DEC);

    // Reset state, with mem_ready high throughout
    step();
    chk("reset_outs", 32'(obs), 32'(17'b0));
    step();
    chk("reset_outs2", 32'(obs), 32'(17'b0));
    resetl = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      @(negedge CLK);
      chk(vecs[i].name, 32'(obs), 32'(vecs[i].exp));
      step();
    end

    // HALT holds for 20 cycles regardless of inputs
    for (int unsigned i = 0; i < 20; i++) begin
      mem_ready = i[0]; opcode = OP_B; zero = ~i[0];
      @(negedge CLK);
      chk($sformatf("halt%0d", i), 32'(obs), 32'(E_HALT));
      step();
    end

    // Reset pulse clears illegal and restarts fetch
    resetl = 1'b0;
    #1;
    chk("halt_rst_outs", 32'(obs), 32'(17'b0));
    step();
    resetl = 1'b1; mem_ready = 1'b0;
    @(negedge CLK);
    chk("post_halt_fetch", 32'(obs), 32'(E_F_WAIT));
    step();

    // Reset during a fetch wait: mem_req drops at once, ready is ignored
    chk("fw_before_rst", 32'(obs), 32'(E_F_WAIT));
    #2 resetl = 1'b0;
    #1;
    chk("fw_rst_memreq", 32'(mem_req), 32'(0));
    mem_ready = 1'b1;
    @(negedge CLK);
    chk("fw_rst_outs", 32'(obs), 32'(17'b0));
    step();
    mem_ready = 1'b0; resetl = 1'b1;
    @(negedge CLK);
    chk("fresh_fetch0", 32'(obs), 32'(E_F_WAIT));
    step();
    @(negedge CLK);
    chk("fresh_fetch1", 32'(obs), 32'(E_F_WAIT));
    mem_ready = 1'b1;
    #1;
    chk("fresh_fetch_rdy", 32'(obs), 32'(E_F_RDY));
    step();
    opcode = OP_B;
    @(negedge CLK);
    chk("fresh_decode", 32'(obs), 32'(E_DEC));

`ifdef MC_PERF_CNT_EN
    // 17 zero-wait B instructions = 51 cycles; 4-bit counters wrap
    step();
    resetl = 1'b0;
    #1;
    chk("cnt_rst_cycle", 32'(cycle_cnt), 32'(0));
    chk("cnt_rst_instr", 32'(instr_cnt), 32'(0));
    step();
    resetl = 1'b1; opcode = OP_B; mem_ready = 1'b1;
    for (int unsigned i = 0; i < 51; i++) step();
    chk("cycle_cnt_wrap", 32'(cycle_cnt), 32'(3));
    chk("instr_cnt_wrap", 32'(instr_cnt), 32'(1));
    chk("cnt_end_fetch", 32'(obs), 32'(E_F_RDY));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
